// File: rtl/fifo_sync_ctrl.sv
// Synchronous single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty
// thresholds and synchronous flush. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module fifo_sync_ctrl #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         w_valid,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         r_ready,
  output logic [WIDTH-1:0]             data_out,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_ctrl: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_ctrl: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_ctrl: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_ctrl: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    fifo_full    = (count == CNT_FULL);
    fifo_empty   = (count == '0);
    almost_full  = (count >= CNT_AF);
    almost_empty = (count <= CNT_AE);
    push         = w_valid & ~fifo_full;
    pop          = r_ready & ~fifo_empty;
    data_out     = fifo_empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; a flush discards the write in flight.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_valid && fifo_full) overflow <= 1'b1;
      else if (err_clr)         overflow <= 1'b0;
      if (r_ready && fifo_empty) underflow <= 1'b1;
      else if (err_clr)          underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Parametrised synchronous single-clock FIFO; successor to the basic w_valid/r_ready FIFO.
- Adds any integer depth (not limited to powers of two), an occupancy count and programmable almost-full/almost-empty thresholds.
- Adds a synchronous flush and optional sticky overflow/underflow error flags.
- Sits between producer and consumer datapath stages wherever elastic buffering with early back-pressure is needed.

Parameters:
WIDTH, 64, data width in bits (>=1)
DEPTH, 4, number of entries (>=2, any integer)
AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of contents
w_valid  in  1  write request
data_in  in  WIDTH  write data
r_ready  in  1  read request (consume head entry)
data_out  out  WIDTH  head entry (show-ahead)
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
Reset (rst_n low, async):
- wr_ptr = 0, rd_ptr = 0, count = 0.
- fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0, data_out = 0.
- Memory array is not reset.

Handshake:
- push = w_valid & !fifo_full; pop = r_ready & !fifo_empty.
- Both are evaluated on pre-edge state.
- Write while full is dropped, even if a pop occurs in the same cycle.
- Read while empty is ignored, even if a push occurs in the same cycle (no write-to-read bypass).

Push: mem[wr_ptr] <= data_in; wr_ptr advances; wraps from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
Pop: rd_ptr advances with the same wrap rule.

Count:
- push only: +1; pop only: -1; both: unchanged; neither: unchanged.
- count is the registered source of all status flags; fifo_full, fifo_empty, almost_full and almost_empty are combinational decodes of count.

data_out:
- Combinational mem[rd_ptr] when !fifo_empty, else 0.
- Head data is valid in the same cycle the consumer asserts r_ready; zero read latency.
- Write-to-read latency is 1 cycle: data written at edge N is visible on data_out after edge N when the FIFO was empty.

Flush:
- Synchronous; highest priority over push/pop in the same cycle.
- Next cycle: pointers = 0, count = 0, flags at reset values.
- Data presented with flush is discarded.

Reset mid-operation: all state returns to reset values immediately; contents are considered lost.

Elaboration check: AF_LEVEL and AE_LEVEL out of range, or DEPTH < 2 -> $error.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.

Defined:
- Extra ports: overflow out 1, underflow out 1, err_clr in 1.
- overflow sets sticky on w_valid & fifo_full.
- underflow sets sticky on r_ready & fifo_empty.
- Both clear on err_clr (synchronous), on flush, or on reset.
- Set takes priority over err_clr in the same cycle.

Undefined: ports absent; illegal requests are silently ignored as above.

Test Plan:
1. Reset then idle, DEPTH=4 -> fifo_empty=1, almost_empty=1, count=0, data_out=0.
2. DEPTH=5, AF_LEVEL=4, push 0..4 with r_ready=0:
   - almost_full rises when count=4.
   - fifo_full when count=5.
   - 6th push (value 5) dropped; count stays 5; with FIFO_ERR_FLAGS_EN, overflow=1.
3. DEPTH=5 wrap: push/pop interleaved for 23 entries (values 0..22) -> pops return 0..22 in order; pointer wrap at 4->0 verified against a scoreboard.
4. Full with simultaneous w_valid=1 and r_ready=1, DEPTH=4 holding 10..13:
   - pop returns 10; new data not written.
   - count = 3 next cycle.
   - Next cycle with count=3: simultaneous push 14/pop returns 11, count stays 3.
5. Count=3, assert flush with w_valid=1 -> next cycle count=0, fifo_empty=1, data_out=0; a later push of 0xAA is read back as 0xAA.
6. Random 600-iteration push/pop enable mix against a TB reference queue -> zero mismatches. With FIFO_ERR_FLAGS_EN, underflow sets on r_ready while empty and clears on err_clr.
